dev_io06xx_resp: RTL and testbench



---
 rtl/dev_io_pkg.sv | 35 +++
 rtl/io51xx_credit.sv | 62 ++++++
 rtl/dev_io06xx_resp.sv | 135 +++++++++++++
 tb/tb_dev_io06xx_resp.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dev_io_pkg.sv
// Shared constants and BCD helpers for the DigDug 06xx/51xx device-bus responder.
package dev_io_pkg;

    localparam logic [15:0] CMD_AD_DEF = 16'h7100;
    localparam logic [15:0] DAT_AD_DEF = 16'h7000;
    localparam logic [7:0]  CMD_READ   = 8'h71;
    localparam logic [7:0]  CMD_WRITE  = 8'hA1;
    localparam logic [7:0]  CMD_IDLE   = 8'h10;
    localparam logic [7:0]  MODE_RAW   = 8'h01;

    // Saturating two-digit BCD increment (99 stays 99).
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Two-digit BCD decrement that stops at zero.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00)
            r = v;
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/io51xx_credit.sv
// Minimal 51xx input path: 2-FF synchronisers, coin/start falling-edge detect,
// and a BCD credit counter that is frozen in raw mode.
module io51xx_credit
    import dev_io_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] inp0,
    input  logic [7:0] inp1,
    input  logic [7:0] inp2,
    input  logic       raw_mode,
    output logic [7:0] inp0_s,
    output logic [7:0] inp1_s,
    output logic [7:0] inp2_s,
    output logic [7:0] credits
);

    logic [23:0] s1_q, s1_d;
    logic [23:0] s2_q, s2_d;
    logic [1:0]  edge_q, edge_d;
    logic [7:0]  cred_q, cred_d;
    logic        coin, start;
    logic [7:0]  tmp;

    always_comb begin
        s1_d   = {inp2, inp1, inp0};
        s2_d   = s1_q;
        // Previous synced levels of start (bit 1) and coin (bit 0).
        edge_d = {s2_q[2], s2_q[0]};
        coin   = edge_q[0] & ~s2_q[0];
        start  = edge_q[1] & ~s2_q[2];
        tmp    = cred_q;
        cred_d = cred_q;
        if (!raw_mode) begin
            if (coin)
                tmp = bcd_inc(tmp);
            if (start)
                tmp = bcd_dec(tmp);
            cred_d = tmp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '1;
            s2_q   <= '1;
            edge_q <= '1;
            cred_q <= 8'h00;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            edge_q <= edge_d;
            cred_q <= cred_d;
        end
    end

    assign inp0_s  = s2_q[7:0];
    assign inp1_s  = s2_q[15:8];
    assign inp2_s  = s2_q[23:16];
    assign credits = cred_q;

endmodule

// File: rtl/dev_io06xx_resp.sv
// DEV-bus responder for the 06xx custom I/O: command/data decode, registered read
// data with DEV_DV, 3-byte read sequencer and the periodic NMI request for CPU0.
module dev_io06xx_resp
    import dev_io_pkg::*;
#(
    parameter logic [15:0] CMD_AD     = CMD_AD_DEF,
    parameter logic [15:0] DAT_AD     = DAT_AD_DEF,
    parameter int          NMI_PERIOD = 4800,
    parameter int          NMI_PW     = 8
) (
    input  logic        DEV_CL,
    input  logic        RST_N,
    input  logic [15:0] DEV_AD,
    input  logic        DEV_RD,
    input  logic        DEV_WR,
    input  logic [7:0]  DEV_DI,
    output logic        DEV_DV,
    output logic [7:0]  DEV_DO,
    input  logic [7:0]  INP0,
    input  logic [7:0]  INP1,
    input  logic [7:0]  INP2,
    output logic        NMI_REQ
);

    localparam int CW = $clog2(NMI_PERIOD);

    logic [7:0]    cmd_q, cmd_d, mode_q, mode_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          nmi_q, nmi_d, dv_q, dv_d;
    logic [7:0]    do_q, do_d;
    logic          prev_wr_q, prev_wr_d, prev_seq_q, prev_seq_d;
    logic [15:0]   prev_ad_q, prev_ad_d;
    logic [7:0]    prev_di_q, prev_di_d;

    logic          cmd_hit, dat_hit, rd_hit, seq_rd, commit, adv, active_q, active_d;
    logic [7:0]    rdata, inp0_s, inp1_s, inp2_s, credits;

    io51xx_credit u_credit (
        .clk      (DEV_CL),
        .rst_n    (RST_N),
        .inp0     (INP0),
        .inp1     (INP1),
        .inp2     (INP2),
        .raw_mode (mode_q == MODE_RAW),
        .inp0_s   (inp0_s),
        .inp1_s   (inp1_s),
        .inp2_s   (inp2_s),
        .credits  (credits)
    );

    always_comb begin
        cmd_hit    = (DEV_AD == CMD_AD);
        dat_hit    = (DEV_AD == DAT_AD);
        rd_hit     = DEV_RD & (cmd_hit | dat_hit);
        seq_rd     = DEV_RD & dat_hit & (cmd_q == CMD_READ);
        // A write held across adjacent slots with identical address/data commits once.
        commit     = DEV_WR & (cmd_hit | dat_hit) &
                     ~(prev_wr_q & (prev_ad_q == DEV_AD) & (prev_di_q == DEV_DI));
        adv        = prev_seq_q & ~(DEV_RD & dat_hit);
        active_q   = (cmd_q[7:5] != 3'd0) & cmd_q[0];

        prev_wr_d  = DEV_WR;
        prev_ad_d  = DEV_AD;
        prev_di_d  = DEV_DI;
        prev_seq_d = seq_rd;

        cmd_d  = cmd_q;
        mode_d = mode_q;
        idx_d  = idx_q;
        if (adv)
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        if (commit && cmd_hit) begin
            cmd_d = DEV_DI;
            idx_d = 2'd0;
        end
        if (commit && dat_hit && cmd_q == CMD_WRITE)
            mode_d = DEV_DI;

        active_d = (cmd_d[7:5] != 3'd0) & cmd_d[0];
        if (commit && cmd_hit)
            cnt_d = '0;
        else if (active_q)
            cnt_d = (cnt_q == CW'(NMI_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
        else
            cnt_d = '0;
        nmi_d = active_d & (cnt_d < CW'(NMI_PW));

        rdata = 8'hFF;
        if (cmd_hit)
            rdata = cmd_q;
        else if (cmd_q == CMD_READ) begin
            case (idx_q)
                2'd0:    rdata = (mode_q == MODE_RAW) ? ~inp0_s : credits;
                2'd1:    rdata = ~inp1_s;
                default: rdata = ~inp2_s;
            endcase
        end
        dv_d = rd_hit;
        do_d = rd_hit ? rdata : 8'h00;
    end

    always_ff @(posedge DEV_CL or negedge RST_N) begin
        if (!RST_N) begin
            cmd_q      <= CMD_IDLE;
            mode_q     <= 8'h00;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            nmi_q      <= 1'b0;
            dv_q       <= 1'b0;
            do_q       <= 8'h00;
            prev_wr_q  <= 1'b0;
            prev_ad_q  <= 16'h0000;
            prev_di_q  <= 8'h00;
            prev_seq_q <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            nmi_q      <= nmi_d;
            dv_q       <= dv_d;
            do_q       <= do_d;
            prev_wr_q  <= prev_wr_d;
            prev_ad_q  <= prev_ad_d;
            prev_di_q  <= prev_di_d;
            prev_seq_q <= prev_seq_d;
        end
    end

    assign DEV_DV  = dv_q;
    assign DEV_DO  = do_q;
    assign NMI_REQ = nmi_q;

endmodule

// File: tb/tb_dev_io06xx_resp.sv
// Directed bench for dev_io06xx_resp: reset state, NMI timing, credit/sequencer
// reads, raw mode and write-merge behaviour, with hand-computed expectations.
module tb_dev_io06xx_resp;

    logic        DEV_CL, RST_N;
    logic [15:0] DEV_AD;
    logic        DEV_RD, DEV_WR;
    logic [7:0]  DEV_DI;
    logic        DEV_DV;
    logic [7:0]  DEV_DO;
    logic [7:0]  INP0, INP1, INP2;
    logic        NMI_REQ;

    int n_checks = 0;
    int n_errors = 0;
    int hi;

    dev_io06xx_resp dut (
        .DEV_CL  (DEV_CL),
        .RST_N   (RST_N),
        .DEV_AD  (DEV_AD),
        .DEV_RD  (DEV_RD),
        .DEV_WR  (DEV_WR),
        .DEV_DI  (DEV_DI),
        .DEV_DV  (DEV_DV),
        .DEV_DO  (DEV_DO),
        .INP0    (INP0),
        .INP1    (INP1),
        .INP2    (INP2),
        .NMI_REQ (NMI_REQ)
    );

    initial DEV_CL = 1'b0;
    always #5 DEV_CL = ~DEV_CL;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Called at a falling edge; commits on the next rising edge.
    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        DEV_AD = addr;
        DEV_DI = data;
        DEV_WR = 1'b1;
        @(negedge DEV_CL);
        DEV_WR = 1'b0;
        DEV_AD = 16'h0000;
    endtask

    // Two-cycle read slot followed by one idle cycle.
    task automatic bus_read(input logic [15:0] addr, input logic [7:0] exp, input string tag);
        DEV_AD = addr;
        DEV_RD = 1'b1;
        @(negedge DEV_CL);
        chk({tag, "_dv"}, 16'(DEV_DV), 16'd1);
        chk(tag, 16'(DEV_DO), 16'(exp));
        @(negedge DEV_CL);
        DEV_RD = 1'b0;
        DEV_AD = 16'h0000;
        @(negedge DEV_CL);
        chk({tag, "_dvoff"}, 16'(DEV_DV), 16'd0);
    endtask

    task automatic pulse_bit(input int b);
        INP0[b] = 1'b0;
        repeat (2) @(negedge DEV_CL);
        INP0[b] = 1'b1;
        repeat (2) @(negedge DEV_CL);
    endtask

    initial begin
        RST_N = 1'b0; DEV_AD = 16'h0000; DEV_RD = 1'b0; DEV_WR = 1'b0; DEV_DI = 8'h00;
        INP0 = 8'hFF; INP1 = 8'hA5; INP2 = 8'h3C;
        repeat (3) @(negedge DEV_CL);
        chk("rst_dv", 16'(DEV_DV), 16'd0);
        chk("rst_do", 16'(DEV_DO), 16'h00);
        chk("rst_nmi", 16'(NMI_REQ), 16'd0);
        RST_N = 1'b1;
        @(negedge DEV_CL);

        bus_read(16'h7100, 8'h10, "cmd_rst");
        hi = 0;
        repeat (10000) begin
            @(negedge DEV_CL);
            if (NMI_REQ) hi++;
        end
        chk("nmi_idle", 16'(hi), 16'd0);

        // NMI period: cycle 0 is the first falling edge after the commit.
        bus_write(16'h7100, 8'h71);
        hi = 0;
        for (int c = 0; c <= 9601; c++) begin
            if (c == 0)    chk("nmi_c0", 16'(NMI_REQ), 16'd1);
            if (c == 7)    chk("nmi_c7", 16'(NMI_REQ), 16'd1);
            if (c == 8)    chk("nmi_c8", 16'(NMI_REQ), 16'd0);
            if (c == 4799) chk("nmi_c4799", 16'(NMI_REQ), 16'd0);
            if (c == 4800) chk("nmi_c4800", 16'(NMI_REQ), 16'd1);
            if (NMI_REQ) hi++;
            if (c < 9601) @(negedge DEV_CL);
        end
        chk("nmi_hi_count", 16'(hi), 16'd18);
        bus_write(16'h7100, 8'h10);
        chk("nmi_off", 16'(NMI_REQ), 16'd0);

        // Credit mode sequencer.
        bus_write(16'h7100, 8'h71);
        repeat (3) pulse_bit(0);
        repeat (4) @(negedge DEV_CL);
        bus_read(16'h7000, 8'h03, "seq0_cred");
        bus_read(16'h7000, 8'h5A, "seq1_inp1");
        bus_read(16'h7000, 8'hC3, "seq2_inp2");
        bus_read(16'h7000, 8'h03, "seq3_wrap");

        repeat (100) pulse_bit(0);
        repeat (4) @(negedge DEV_CL);
        bus_write(16'h7100, 8'h71);
        bus_read(16'h7000, 8'h99, "cred_sat");

        // Reset, then coin and start on the same cycle at zero credits.
        RST_N = 1'b0;
        @(negedge DEV_CL);
        chk("rst2_nmi", 16'(NMI_REQ), 16'd0);
        RST_N = 1'b1;
        @(negedge DEV_CL);
        bus_write(16'h7100, 8'h71);
        INP0 = 8'hFA;
        repeat (2) @(negedge DEV_CL);
        INP0 = 8'hFF;
        repeat (4) @(negedge DEV_CL);
        bus_read(16'h7000, 8'h00, "coin_start_0");

        repeat (10) pulse_bit(0);
        repeat (4) @(negedge DEV_CL);
        bus_write(16'h7100, 8'h71);
        bus_read(16'h7000, 8'h10, "cred_10");
        pulse_bit(2);
        repeat (4) @(negedge DEV_CL);
        bus_write(16'h7100, 8'h71);
        bus_read(16'h7000, 8'h09, "start_dec");

        // Raw mode: byte 0 is ~INP0 and credits stay frozen.
        bus_write(16'h7100, 8'hA1);
        bus_write(16'h7000, 8'h01);
        bus_write(16'h7100, 8'h71);
        INP0 = 8'hFE;
        repeat (4) @(negedge DEV_CL);
        bus_read(16'h7000, 8'h01, "raw_inp0");
        INP0 = 8'hFF;
        repeat (2) @(negedge DEV_CL);
        repeat (2) pulse_bit(0);
        repeat (4) @(negedge DEV_CL);
        bus_write(16'h7100, 8'hA1);
        bus_write(16'h7000, 8'h00);
        bus_write(16'h7100, 8'h71);
        bus_read(16'h7000, 8'h09, "raw_frozen");

        // Write held for two cycles commits once (NMI restarts only once).
        DEV_AD = 16'h7100; DEV_DI = 8'h71; DEV_WR = 1'b1;
        @(negedge DEV_CL);
        chk("hold_nmi_c0", 16'(NMI_REQ), 16'd1);
        @(negedge DEV_CL);
        DEV_WR = 1'b0; DEV_AD = 16'h0000;
        repeat (6) @(negedge DEV_CL);
        chk("hold_nmi_c7", 16'(NMI_REQ), 16'd1);
        @(negedge DEV_CL);
        chk("hold_nmi_c8", 16'(NMI_REQ), 16'd0);
        bus_read(16'h7000, 8'h09, "hold_idx0");

        // Unmapped address never asserts DEV_DV.
        DEV_AD = 16'h7200; DEV_RD = 1'b1;
        @(negedge DEV_CL);
        chk("miss_dv1", 16'(DEV_DV), 16'd0);
        @(negedge DEV_CL);
        chk("miss_dv2", 16'(DEV_DV), 16'd0);
        DEV_RD = 1'b0; DEV_AD = 16'h0000;
        @(negedge DEV_CL);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
